// File: rtl/ysyx_23060025_mem_arbiter.sv
// ysyx_23060025_mem_arbiter: round-robin arbiter sharing one SRAM port between IFU reads and LSU reads/writes
module ysyx_23060025_mem_arbiter #(
    parameter int ADDR_LEN = 32,
    parameter int DATA_LEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_LEN-1:0] ifu_raddr,
    output logic                ifu_rsp_valid,
    output logic [DATA_LEN-1:0] ifu_rdata,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic                lsu_wen,
    input  logic [ADDR_LEN-1:0] lsu_addr,
    input  logic [DATA_LEN-1:0] lsu_wdata,
    input  logic [7:0]          lsu_wmask,
    output logic                lsu_rsp_valid,
    output logic [DATA_LEN-1:0] lsu_rdata,
    output logic                sram_ren,
    output logic                sram_wen,
    output logic [ADDR_LEN-1:0] sram_raddr,
    output logic [ADDR_LEN-1:0] sram_waddr,
    output logic [DATA_LEN-1:0] sram_wdata,
    output logic [7:0]          sram_wmask,
    input  logic [DATA_LEN-1:0] sram_rdata
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    state_t              state_q, state_d;
    logic                ptr_q, ptr_d;
    logic                id_q, id_d;
    logic                wen_q, wen_d;
    logic [ADDR_LEN-1:0] addr_q, addr_d;
    logic [DATA_LEN-1:0] wdata_q, wdata_d;
    logic [7:0]          wmask_q, wmask_d;
    logic                idle, issue, resp, hs;
    // Grant and response decode; ptr/id use 1 for LSU, 0 for IFU, and reset forces every strobe low
    always_comb begin
        idle          = state_q == IDLE && !rst;
        issue         = state_q == ISSUE && !rst;
        resp          = state_q == RESP && !rst;
        ifu_req_ready = idle && ifu_req_valid && (!lsu_req_valid || ptr_q);
        lsu_req_ready = idle && lsu_req_valid && (!ifu_req_valid || !ptr_q);
        hs            = ifu_req_ready || lsu_req_ready;
        sram_ren      = issue && !wen_q;
        sram_wen      = issue && wen_q;
        sram_raddr    = sram_ren ? addr_q : '0;
        sram_waddr    = sram_wen ? addr_q : '0;
        sram_wdata    = sram_wen ? wdata_q : '0;
        sram_wmask    = sram_wen ? wmask_q : '0;
        ifu_rsp_valid = resp && !id_q;
        lsu_rsp_valid = resp && id_q;
        ifu_rdata     = (ifu_rsp_valid && !wen_q) ? sram_rdata : '0;
        lsu_rdata     = (lsu_rsp_valid && !wen_q) ? sram_rdata : '0;
    end
    // Next state: advance through ISSUE/RESP and capture the granted request on a handshake
    always_comb begin
        state_d = state_q == IDLE ? (hs ? ISSUE : IDLE) : (state_q == ISSUE ? RESP : IDLE);
        ptr_d   = hs ? lsu_req_ready : ptr_q;
        id_d    = hs ? lsu_req_ready : id_q;
        wen_d   = hs ? lsu_req_ready && lsu_wen : wen_q;
        addr_d  = hs ? (lsu_req_ready ? lsu_addr : ifu_raddr) : addr_q;
        wdata_d = hs ? (lsu_req_ready ? lsu_wdata : '0) : wdata_q;
        wmask_d = hs ? (lsu_req_ready ? lsu_wmask : 8'h00) : wmask_q;
    end
    // State register; reset returns to IDLE with the pointer on LSU so IFU wins the first conflict
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 1'b1;
            id_q    <= 1'b0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
        end
    end
endmodule

// File: tb/tb_ysyx_23060025_mem_arbiter.sv
// tb_ysyx_23060025_mem_arbiter: directed vector bench for the IFU/LSU SRAM arbiter
module tb_ysyx_23060025_mem_arbiter;
    typedef struct packed {
        logic        rst, iv;
        logic [31:0] ia;
        logic        lv, lw;
        logic [31:0] la, wd;
        logic [7:0]  wm;
        logic [31:0] rd;
    } in_t;
    typedef struct packed {
        logic        ir, lr, ren, wen;
        logic [31:0] raddr, waddr, wdata;
        logic [7:0]  wmask;
        logic        irv;
        logic [31:0] ird;
        logic        lrv;
        logic [31:0] lrd;
    } out_t;
    typedef struct {
        string name;
        in_t   i;
        out_t  o;
    } vec_t;

    logic clk = 1'b0;
    logic rst, ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
    logic lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid, sram_ren, sram_wen;
    logic [31:0] ifu_raddr, ifu_rdata, lsu_addr, lsu_wdata, lsu_rdata;
    logic [31:0] sram_raddr, sram_waddr, sram_wdata, sram_rdata;
    logic [7:0] lsu_wmask, sram_wmask;
    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    ysyx_23060025_mem_arbiter #(.ADDR_LEN(32), .DATA_LEN(32)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_raddr(ifu_raddr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rdata(lsu_rdata),
        .sram_ren(sram_ren), .sram_wen(sram_wen), .sram_raddr(sram_raddr), .sram_waddr(sram_waddr),
        .sram_wdata(sram_wdata), .sram_wmask(sram_wmask), .sram_rdata(sram_rdata)
    );

    function automatic in_t mi(logic r, logic iv, logic [31:0] ia, logic lv, logic lw,
                               logic [31:0] la, logic [31:0] wd, logic [7:0] wm, logic [31:0] rd);
        in_t x;
        x.rst = r; x.iv = iv; x.ia = ia; x.lv = lv; x.lw = lw;
        x.la = la; x.wd = wd; x.wm = wm; x.rd = rd;
        return x;
    endfunction

    function automatic out_t mo(logic ir, logic lr, logic ren, logic wen, logic [31:0] ra,
                                logic [31:0] wa, logic [31:0] wd, logic [7:0] wm,
                                logic irv, logic [31:0] ird, logic lrv, logic [31:0] lrd);
        out_t x;
        x.ir = ir; x.lr = lr; x.ren = ren; x.wen = wen; x.raddr = ra; x.waddr = wa;
        x.wdata = wd; x.wmask = wm; x.irv = irv; x.ird = ird; x.lrv = lrv; x.lrd = lrd;
        return x;
    endfunction

    task automatic drive(input in_t x);
        rst = x.rst; ifu_req_valid = x.iv; ifu_raddr = x.ia; lsu_req_valid = x.lv;
        lsu_wen = x.lw; lsu_addr = x.la; lsu_wdata = x.wd; lsu_wmask = x.wm; sram_rdata = x.rd;
    endtask

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic monitor();
        check("ready_onehot", {255'd0, ifu_req_ready && lsu_req_ready}, 256'd0);
        check("sram_en_onehot", {255'd0, sram_ren && sram_wen}, 256'd0);
    endtask

    out_t got;
    assign got = mo(ifu_req_ready, lsu_req_ready, sram_ren, sram_wen, sram_raddr, sram_waddr,
                    sram_wdata, sram_wmask, ifu_rsp_valid, ifu_rdata, lsu_rsp_valid, lsu_rdata);

    vec_t v[$];
    out_t z;

    task automatic add(input string n, input in_t i, input out_t o);
        vec_t e;
        e.name = n; e.i = i; e.o = o;
        v.push_back(e);
    endtask

    initial begin
        int hs_cyc[$];
        int hs_who[$];
        int exp_cyc[4] = '{0, 3, 6, 9};
        int exp_who[4] = '{0, 1, 0, 1};
        z = '0;
        add("rst_hold",    mi(1,1,32'h80000000,1,1,32'h80001000,32'h1,8'hff,0), z);
        add("ifu_hs",      mi(0,1,32'h80000000,0,0,0,0,0,0), mo(1,0,0,0,0,0,0,0,0,0,0,0));
        add("ifu_issue",   mi(0,0,32'h12345678,0,0,0,0,0,0), mo(0,0,1,0,32'h80000000,0,0,0,0,0,0,0));
        add("ifu_resp",    mi(0,0,0,0,0,0,0,0,32'h413), mo(0,0,0,0,0,0,0,0,1,32'h413,0,0));
        add("lsu_w_hs",    mi(0,0,0,1,1,32'h80001000,32'hdeadbeef,8'h0f,0), mo(0,1,0,0,0,0,0,0,0,0,0,0));
        add("lsu_w_issue", mi(0,0,0,0,0,0,0,0,0), mo(0,0,0,1,0,32'h80001000,32'hdeadbeef,8'h0f,0,0,0,0));
        add("lsu_w_resp",  mi(0,0,0,0,0,0,0,0,32'hffffffff), mo(0,0,0,0,0,0,0,0,0,0,1,0));
        add("lsu_r_hs",    mi(0,0,0,1,0,32'h80000010,0,0,0), mo(0,1,0,0,0,0,0,0,0,0,0,0));
        add("lsu_r_hold",  mi(0,0,0,1,0,32'h80000010,0,0,0), mo(0,0,1,0,32'h80000010,0,0,0,0,0,0,0));
        add("lsu_r_resp",  mi(0,0,0,0,0,0,0,0,32'hcafef00d), mo(0,0,0,0,0,0,0,0,0,0,1,32'hcafef00d));
        add("wm0_hs",      mi(0,0,0,1,1,32'h80002000,32'h11223344,8'h00,0), mo(0,1,0,0,0,0,0,0,0,0,0,0));
        add("wm0_issue",   mi(0,0,0,0,0,0,0,0,0), mo(0,0,0,1,0,32'h80002000,32'h11223344,8'h00,0,0,0,0));
        add("wm0_resp",    mi(0,0,0,0,0,0,0,0,32'h5a5a5a5a), mo(0,0,0,0,0,0,0,0,0,0,1,0));
        add("rr_ifu",      mi(0,1,32'h80000004,1,0,32'h80000020,0,0,0), mo(1,0,0,0,0,0,0,0,0,0,0,0));
        add("rr_hold",     mi(0,0,0,1,0,32'h80000020,0,0,0), mo(0,0,1,0,32'h80000004,0,0,0,0,0,0,0));
        add("rr_resp",     mi(0,0,0,1,0,32'h80000020,0,0,32'h13), mo(0,0,0,0,0,0,0,0,1,32'h13,0,0));
        add("rr_lsu",      mi(0,1,32'h80000008,1,0,32'h80000020,0,0,0), mo(0,1,0,0,0,0,0,0,0,0,0,0));
        add("rr_issue",    mi(0,1,32'h80000008,0,0,0,0,0,0), mo(0,0,1,0,32'h80000020,0,0,0,0,0,0,0));
        add("rr_resp2",    mi(0,1,32'h80000008,0,0,0,0,0,32'h55), mo(0,0,0,0,0,0,0,0,0,0,1,32'h55));
        add("abort_hs",    mi(0,0,0,1,0,32'h80000030,0,0,0), mo(0,1,0,0,0,0,0,0,0,0,0,0));
        add("abort_rst",   mi(1,0,0,0,0,0,0,0,0), z);
        add("abort_idle",  mi(0,0,0,0,0,0,0,0,32'h77), z);
        add("rst2_hs",     mi(0,1,32'h80000040,0,0,0,0,0,0), mo(1,0,0,0,0,0,0,0,0,0,0,0));
        add("rst2_issue",  mi(0,0,0,0,0,0,0,0,0), mo(0,0,1,0,32'h80000040,0,0,0,0,0,0,0));
        add("rst2_rst",    mi(1,0,0,0,0,0,0,0,32'h99), z);
        add("ptr_reset",   mi(0,1,32'h80000044,1,0,32'h80000050,0,0,0), mo(1,0,0,0,0,0,0,0,0,0,0,0));
        add("ptr_issue",   mi(0,0,0,0,0,0,0,0,0), mo(0,0,1,0,32'h80000044,0,0,0,0,0,0,0));
        add("ptr_resp",    mi(0,0,0,0,0,0,0,0,32'habcd), mo(0,0,0,0,0,0,0,0,1,32'habcd,0,0));

        drive(mi(1,0,0,0,0,0,0,0,0));
        @(posedge clk); #1;
        foreach (v[k]) begin
            drive(v[k].i);
            @(negedge clk);
            check(v[k].name, {66'd0, got}, {66'd0, v[k].o});
            monitor();
            @(posedge clk); #1;
        end

        drive(mi(1,0,0,0,0,0,0,0,0));
        @(posedge clk); #1;
        drive(mi(0,1,32'h80000100,1,0,32'h80000200,0,0,32'h1));
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            monitor();
            if (ifu_req_ready) begin hs_cyc.push_back(c); hs_who.push_back(0); end
            if (lsu_req_ready) begin hs_cyc.push_back(c); hs_who.push_back(1); end
            @(posedge clk); #1;
        end
        check("rr_count", 256'(hs_cyc.size()), 256'd4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rr_grant%0d", k),
                  k < hs_cyc.size() ? {192'd0, 32'(hs_cyc[k]), 32'(hs_who[k])} : {256{1'b1}},
                  {192'd0, 32'(exp_cyc[k]), 32'(exp_who[k])});
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/ysyx_23060025_mem_arbiter.md
YSYX_23060025_MEM_ARBITER -- requirements
Module: ysyx_23060025_mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_LEN, 32, address width; DATA_LEN, 32, data width.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 ifu_req_valid  in  1  IFU read request pending.
REQ-005 ifu_req_ready  out  1  IFU request accepted this cycle when high with valid.
REQ-006 ifu_raddr  in  ADDR_LEN  IFU read address.
REQ-007 ifu_rsp_valid  out  1  one-cycle pulse, IFU read data valid.
REQ-008 ifu_rdata  out  DATA_LEN  IFU read data.
REQ-009 lsu_req_valid  in  1  LSU request pending.
REQ-010 lsu_req_ready  out  1  LSU request accepted this cycle when high with valid.
REQ-011 lsu_wen  in  1  1 = write, 0 = read.
REQ-012 lsu_addr  in  ADDR_LEN  LSU address.
REQ-013 lsu_wdata  in  DATA_LEN  LSU write data.
REQ-014 lsu_wmask  in  8  LSU write byte mask.
REQ-015 lsu_rsp_valid  out  1  one-cycle pulse, LSU read data valid or write done.
REQ-016 lsu_rdata  out  DATA_LEN  LSU read data.
REQ-017 sram_ren / sram_wen  out  1 each  SRAM read / write enable.
REQ-018 sram_raddr / sram_waddr  out  ADDR_LEN each  SRAM read / write address.
REQ-019 sram_wdata  out  DATA_LEN; sram_wmask  out  8  SRAM write data and mask.
REQ-020 sram_rdata  in  DATA_LEN  SRAM read data, registered one cycle after sram_ren.

Function
REQ-021 FSM states SHALL be IDLE, ISSUE, RESP; IDLE->ISSUE on accepted handshake, ISSUE->RESP unconditionally, RESP->IDLE unconditionally.
REQ-022 Handshakes SHALL occur only in IDLE; both ready outputs SHALL be 0 in ISSUE and RESP.
REQ-023 Ready outputs SHALL be combinational: only one requester valid -> that requester's ready = 1; both valid -> grant by round-robin pointer.
REQ-024 The round-robin pointer SHALL record the last granted requester, update only on an accepted handshake, and reset to LSU, so the IFU wins the first conflict.
REQ-025 At most one ready SHALL be high in any cycle.
REQ-026 On handshake, the arbiter SHALL latch requester id, wen, address, wdata, and wmask; later input changes SHALL have no effect on the transaction.
REQ-027 IFU transactions SHALL be reads: wen = 0, wdata = 0, wmask = 0.
REQ-028 In ISSUE, read -> sram_ren = 1 with sram_raddr = latched address; write -> sram_wen = 1 with sram_waddr, sram_wdata, and sram_wmask from latches; each enable SHALL last exactly one cycle.
REQ-029 Outside ISSUE, sram_ren, sram_wen, and all SRAM address, data, and mask outputs SHALL be 0.
REQ-030 In RESP, the granted requester's rsp_valid SHALL be 1 for exactly one cycle; the other requester's rsp_valid SHALL be 0.
REQ-031 In RESP on a read, the granted requester's rdata SHALL equal sram_rdata; for writes and all other cycles, rdata outputs SHALL be 0.
REQ-032 Latency SHALL be: handshake edge at cycle T, SRAM enable in T+1, rsp_valid in T+2; next handshake no earlier than T+3.
REQ-033 Requesters SHALL accept rsp_valid unconditionally; there is no response back-pressure.
REQ-034 A write with wmask = 8'h00 SHALL complete the full sequence with sram_wen = 1 and a response pulse.
REQ-035 A requester may hold valid across ISSUE and RESP; it SHALL be re-arbitrated on return to IDLE.

Reset
REQ-036 While rst = 1: ready outputs, sram_ren, sram_wen, and rsp_valid SHALL be forced to 0 combinationally.
REQ-037 At a rising edge with rst = 1: state -> IDLE, pointer -> LSU, all latches -> 0.
REQ-038 Reset asserted in ISSUE or RESP SHALL abort the transaction with no response pulse after reset.
REQ-039 The first handshake after reset SHALL be possible in the first cycle with rst = 0.

Verification
REQ-040 Single IFU read: ifu_raddr = 0x80000000, SRAM returns 0x00000413 -> ready at T, sram_ren and sram_raddr = 0x80000000 at T+1, ifu_rsp_valid = 1 and ifu_rdata = 0x00000413 at T+2.
REQ-041 LSU write: lsu_addr = 0x80001000, wdata = 0xDEADBEEF, wmask = 0x0F -> sram_wen = 1 with those values at T+1 only; lsu_rsp_valid at T+2 with lsu_rdata = 0.
REQ-042 Both valid continuously after reset -> grant order IFU, LSU, IFU, LSU with handshakes at T, T+3, T+6, T+9.
REQ-043 rst pulsed during ISSUE of an LSU read -> no lsu_rsp_valid; sram_ren = 0 from the reset cycle; IDLE afterwards with pointer = LSU.
REQ-044 Address changed during ISSUE -> SRAM address still equals the latched value; rsp routed only to the original requester.
REQ-045 Every cycle, assert !(ifu_req_ready && lsu_req_ready) and !(sram_ren && sram_wen).
